// File: rtl/ucode_sequencer.sv
// ---------------------------------------------------------------------------
// ucode_sequencer
//
// Microcode responder for the fetch-stage multiply trap. When fetch traps a
// MUL-class opcode it freezes the PC and hands over the opcode, rd, rs and
// imm fields. This block replays the multiply as a stream of ghost
// instructions (MOVI/MOV/ADD/SUBI/CMPI) over a valid/ready handshake. Then it
// pulses ucode_done so fetch can resume.
//
// Register-count loops are steered by the zero flag that execute returns for
// each CMPI, so no branch instruction is ever emitted.
//
// Instruction format: {op[6:0], rd[3:0], rs[3:0], 1'b0, imm[15:0]}.
// The register operand of MOVI/CMPI sits in rd with rs = 0.
// SUBI carries GCNT in both rd and rs.
// The three-register ADD carries rt in imm[3:0].
//
// Optional feature (macro UCODE_IMM_UNROLL_EN):
//   defined   - immediate forms unroll N ADDs from an internal 16-bit counter,
//               with no CMPI/SUBI and no execute feedback.
//   undefined - immediate forms reuse the register-form loop and load the
//               loop counter with MOVI GCNT, #N instead of MOV GCNT, rt.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   trap_valid          fetch presents a trapped opcode (sampled in IDLE only)
//   mul_opcode/rd/rs/imm trapped instruction fields (imm[3:0] = rt in
//                       register forms)
//   ghost_ready         fetch accepts ghost_instruction this cycle
//   exe_flag_valid      execute resolved the last CMPI (used in WAITF only)
//   exe_zero            zero flag of that CMPI
//   ghost_instruction   emitted instruction
//   ghost_valid         ghost_instruction is valid
//   ghost_PC            micro-step index of the current state
//   ucode_flag          sequencer busy
//   ucode_done          one-cycle pulse at the end of a sequence
//   trap_error          one-cycle pulse when an illegal opcode is trapped
// ---------------------------------------------------------------------------
module ucode_sequencer #(
  parameter logic [6:0] OP_MOVI = 7'b0100001,
  parameter logic [6:0] OP_MOV  = 7'b0100000,
  parameter logic [6:0] OP_ADD  = 7'b0000000,
  parameter logic [6:0] OP_SUBI = 7'b0001001,
  parameter logic [6:0] OP_CMPI = 7'b0101001,
  parameter logic [3:0] GACC    = 4'd14,
  parameter logic [3:0] GCNT    = 4'd13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_valid,
  input  logic [6:0]  mul_opcode,
  input  logic [3:0]  mul_rd,
  input  logic [3:0]  mul_rs,
  input  logic [15:0] mul_imm,
  input  logic        ghost_ready,
  input  logic        exe_flag_valid,
  input  logic        exe_zero,
  output logic [31:0] ghost_instruction,
  output logic        ghost_valid,
  output logic [3:0]  ghost_PC,
  output logic        ucode_flag,
  output logic        ucode_done,
  output logic        trap_error
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_MOV0  = 4'd1,
    S_LDC   = 4'd2,
    S_CMP   = 4'd3,
    S_WAITF = 4'd4,
    S_ADD   = 4'd5,
    S_SUB   = 4'd6,
    S_WB    = 4'd7,
    S_SETF  = 4'd8,
    S_FIN   = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic        imm_form_q, imm_form_d;
  logic        setf_q, setf_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rs_q, rs_d;
  logic [15:0] imm_q, imm_d;
`ifdef UCODE_IMM_UNROLL_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  logic [31:0] ghost_instruction_q, ghost_instruction_d;
  logic        ghost_valid_q, ghost_valid_d;
  logic [3:0]  ghost_pc_q, ghost_pc_d;
  logic        ucode_flag_q, ucode_flag_d;
  logic        ucode_done_q, ucode_done_d;
  logic        trap_error_q, trap_error_d;

  logic        hs;

  // Pack one ghost instruction in the fetch format.
  function automatic logic [31:0] encode(input logic [6:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, 1'b0, imm};
  endfunction

  // Only the four MUL-class encodings are serviced.
  function automatic logic is_mul_opcode(input logic [6:0] op);
    logic legal;
    case (op)
      7'b0010000: legal = 1'b1;
      7'b0011000: legal = 1'b1;
      7'b0110000: legal = 1'b1;
      7'b0111000: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
    return legal;
  endfunction

  assign hs = ghost_valid_q & ghost_ready;

  // Next-state, field latching and loop-counter logic.
  always_comb begin
    state_d      = state_q;
    imm_form_d   = imm_form_q;
    setf_d       = setf_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    imm_d        = imm_q;
`ifdef UCODE_IMM_UNROLL_EN
    cnt_d        = cnt_q;
`endif
    trap_error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (trap_valid) begin
          imm_form_d = mul_opcode[5];
          setf_d     = mul_opcode[3];
          rd_d       = mul_rd;
          rs_d       = mul_rs;
          imm_d      = mul_imm;
          if (is_mul_opcode(mul_opcode)) begin
            state_d = S_MOV0;
          end else begin
            trap_error_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MOV0: begin
        if (hs) begin
`ifdef UCODE_IMM_UNROLL_EN
          if (imm_form_q) begin
            cnt_d   = imm_q;
            state_d = (imm_q != 16'd0) ? S_ADD : S_WB;
          end else begin
            state_d = S_LDC;
          end
`else
          state_d = S_LDC;
`endif
        end else begin
          state_d = S_MOV0;
        end
      end
      S_LDC: begin
        if (hs) begin
          state_d = S_CMP;
        end else begin
          state_d = S_LDC;
        end
      end
      S_CMP: begin
        if (hs) begin
          state_d = S_WAITF;
        end else begin
          state_d = S_CMP;
        end
      end
      S_WAITF: begin
        // The loop exit is decided by execute; nothing is emitted meanwhile.
        if (exe_flag_valid) begin
          state_d = exe_zero ? S_WB : S_ADD;
        end else begin
          state_d = S_WAITF;
        end
      end
      S_ADD: begin
        if (hs) begin
`ifdef UCODE_IMM_UNROLL_EN
          if (imm_form_q) begin
            // cnt holds the ADDs still owed including this one, so 1 means last.
            cnt_d   = cnt_q - 16'd1;
            state_d = (cnt_q == 16'd1) ? S_WB : S_ADD;
          end else begin
            state_d = S_SUB;
          end
`else
          state_d = S_SUB;
`endif
        end else begin
          state_d = S_ADD;
        end
      end
      S_SUB: begin
        if (hs) begin
          state_d = S_CMP;
        end else begin
          state_d = S_SUB;
        end
      end
      S_WB: begin
        if (hs) begin
          state_d = setf_q ? S_SETF : S_FIN;
        end else begin
          state_d = S_WB;
        end
      end
      S_SETF: begin
        if (hs) begin
          state_d = S_FIN;
        end else begin
          state_d = S_SETF;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    ghost_instruction_d = 32'd0;
    ghost_valid_d       = 1'b0;
    ghost_pc_d          = 4'd0;
    ucode_flag_d        = 1'b1;
    ucode_done_d        = 1'b0;

    case (state_d)
      S_IDLE: begin
        ucode_flag_d = 1'b0;
      end
      S_MOV0: begin
        ghost_valid_d       = 1'b1;
        ghost_pc_d          = 4'd0;
        ghost_instruction_d = encode(OP_MOVI, GACC, 4'd0, 16'd0);
      end
      S_LDC: begin
        ghost_valid_d = 1'b1;
        ghost_pc_d    = 4'd1;
`ifdef UCODE_IMM_UNROLL_EN
        ghost_instruction_d = encode(OP_MOV, GCNT, imm_d[3:0], 16'd0);
`else
        if (imm_form_d) begin
          ghost_instruction_d = encode(OP_MOVI, GCNT, 4'd0, imm_d);
        end else begin
          ghost_instruction_d = encode(OP_MOV, GCNT, imm_d[3:0], 16'd0);
        end
`endif
      end
      S_CMP: begin
        ghost_valid_d       = 1'b1;
        ghost_pc_d          = 4'd2;
        ghost_instruction_d = encode(OP_CMPI, GCNT, 4'd0, 16'd0);
      end
      S_WAITF: begin
        ghost_pc_d = 4'd2;
      end
      S_ADD: begin
        ghost_valid_d       = 1'b1;
        ghost_pc_d          = 4'd3;
        ghost_instruction_d = encode(OP_ADD, GACC, GACC, {12'd0, rs_d});
      end
      S_SUB: begin
        ghost_valid_d       = 1'b1;
        ghost_pc_d          = 4'd4;
        ghost_instruction_d = encode(OP_SUBI, GCNT, GCNT, 16'd1);
      end
      S_WB: begin
        ghost_valid_d       = 1'b1;
        ghost_pc_d          = 4'd5;
        ghost_instruction_d = encode(OP_MOV, rd_d, GACC, 16'd0);
      end
      S_SETF: begin
        ghost_valid_d       = 1'b1;
        ghost_pc_d          = 4'd6;
        ghost_instruction_d = encode(OP_CMPI, rd_d, 4'd0, 16'd0);
      end
      S_FIN: begin
        ucode_flag_d = 1'b0;
        ucode_done_d = 1'b1;
      end
      default: begin
        ucode_flag_d = 1'b0;
      end
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= S_IDLE;
      imm_form_q          <= 1'b0;
      setf_q              <= 1'b0;
      rd_q                <= 4'd0;
      rs_q                <= 4'd0;
      imm_q               <= 16'd0;
`ifdef UCODE_IMM_UNROLL_EN
      cnt_q               <= 16'd0;
`endif
      ghost_instruction_q <= 32'd0;
      ghost_valid_q       <= 1'b0;
      ghost_pc_q          <= 4'd0;
      ucode_flag_q        <= 1'b0;
      ucode_done_q        <= 1'b0;
      trap_error_q        <= 1'b0;
    end else begin
      state_q             <= state_d;
      imm_form_q          <= imm_form_d;
      setf_q              <= setf_d;
      rd_q                <= rd_d;
      rs_q                <= rs_d;
      imm_q               <= imm_d;
`ifdef UCODE_IMM_UNROLL_EN
      cnt_q               <= cnt_d;
`endif
      ghost_instruction_q <= ghost_instruction_d;
      ghost_valid_q       <= ghost_valid_d;
      ghost_pc_q          <= ghost_pc_d;
      ucode_flag_q        <= ucode_flag_d;
      ucode_done_q        <= ucode_done_d;
      trap_error_q        <= trap_error_d;
    end
  end

  assign ghost_instruction = ghost_instruction_q;
  assign ghost_valid       = ghost_valid_q;
  assign ghost_PC          = ghost_pc_q;
  assign ucode_flag        = ucode_flag_q;
  assign ucode_done        = ucode_done_q;
  assign trap_error        = trap_error_q;

endmodule
